// File: rtl/pipeline_stall_controller_pkg.sv
// Shared state encodings and enable bundle for the pipeline stall controller.
package risc_pipe_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 3'd0,
        ST_STALL    = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_HALTED   = 3'd4
    } pipe_state_e;

    typedef struct packed {
        logic pc_write;
        logic id_write;
        logic ifid_flush;
        logic ctrl_flush;
        logic exmem_write;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN = '{pc_write: 1'b1, id_write: 1'b1, ifid_flush: 1'b0,
                                        ctrl_flush: 1'b0, exmem_write: 1'b1};
    localparam pipe_ctrl_t CTRL_STALL = '{pc_write: 1'b0, id_write: 1'b0, ifid_flush: 1'b0,
                                          ctrl_flush: 1'b1, exmem_write: 1'b1};
    localparam pipe_ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, id_write: 1'b1, ifid_flush: 1'b1,
                                           ctrl_flush: 1'b1, exmem_write: 1'b1};
    localparam pipe_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, id_write: 1'b0, ifid_flush: 1'b0,
                                           ctrl_flush: 1'b0, exmem_write: 1'b0};

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard-side requests and pipeline-register enables between the HDU and the stall controller.
interface pipeline_stall_controller_if #(
    parameter int unsigned CNT_W = 16
);
    import risc_pipe_pkg::*;

    logic               hdu_stall;
    logic               br_taken;
    logic               mem_busy;
    logic               halt;
    logic               PCwrite;
    logic               Id_write;
    logic               ifid_flush;
    logic               ctrl_flush;
    logic               exmem_write;
    logic               stall_timeout;
    logic [STATE_W-1:0] pipe_state;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output hdu_stall, br_taken, mem_busy, halt,
        input  PCwrite, Id_write, ifid_flush, ctrl_flush, exmem_write,
        input  stall_timeout, pipe_state, stall_cnt, flush_cnt
    );

    modport slave (
        input  hdu_stall, br_taken, mem_busy, halt,
        output PCwrite, Id_write, ifid_flush, ctrl_flush, exmem_write,
        output stall_timeout, pipe_state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter for the performance counters; only compiled when PERF_CNT_EN is defined.
`ifdef PERF_CNT_EN
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/pipeline_stall_controller.sv
// Registered FSM merging halt, mem_busy, branch redirect and load-use stall into pipeline enables.
// Optional PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipeline_stall_controller
    import risc_pipe_pkg::*;
#(
    parameter int unsigned BR_PENALTY = 1,
    parameter int unsigned MAX_STALL  = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_stall_controller_if.slave  ctl
);

    localparam logic [1:0] FCNT_INIT = 2'(BR_PENALTY);
    localparam logic [2:0] SCNT_MAX  = 3'(MAX_STALL);

    pipe_state_e state_q, state_d;
    pipe_state_e resume_q, resume_d;
    pipe_state_e eff_state;
    logic [1:0]  fcnt_q, fcnt_d;
    logic [2:0]  scnt_q, scnt_d;
    logic        timeout_q, timeout_d;
    pipe_ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            resume_q  <= ST_RUN;
            fcnt_q    <= '0;
            scnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            fcnt_q    <= fcnt_d;
            scnt_q    <= scnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        ctrl      = CTRL_RUN;
        state_d   = state_q;
        resume_d  = resume_q;
        fcnt_d    = fcnt_q;
        scnt_d    = scnt_q;
        timeout_d = timeout_q;

        // The cycle memory becomes ready behaves as the interrupted state, so a frozen
        // stall or flush resumes with its held count without losing a cycle.
        eff_state = state_q;
        if ((state_q == ST_MEM_WAIT) && !ctl.mem_busy) begin
            eff_state = resume_q;
        end

        if (state_q == ST_HALTED) begin
            ctrl = CTRL_FREEZE;
        end else if (ctl.halt) begin
            ctrl    = CTRL_FREEZE;
            state_d = ST_HALTED;
        end else if (ctl.mem_busy) begin
            ctrl    = CTRL_FREEZE;
            state_d = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                resume_d = state_q;
            end
        end else if (ctl.br_taken) begin
            ctrl = CTRL_BRANCH;
            if (BR_PENALTY > 0) begin
                state_d = ST_FLUSH;
                fcnt_d  = FCNT_INIT;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (eff_state)
                ST_RUN: begin
                    state_d = ST_RUN;
                    if (ctl.hdu_stall) begin
                        ctrl    = CTRL_STALL;
                        scnt_d  = 3'd1;
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (!ctl.hdu_stall) begin
                        state_d = ST_RUN;
                    end else if (scnt_q >= SCNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        ctrl    = CTRL_STALL;
                        scnt_d  = scnt_q + 3'd1;
                        state_d = ST_STALL;
                    end
                end
                ST_FLUSH: begin
                    ctrl = CTRL_BRANCH;
                    if (fcnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                    end else begin
                        fcnt_d  = fcnt_q - 2'd1;
                        state_d = ST_FLUSH;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign ctl.PCwrite       = ctrl.pc_write;
    assign ctl.Id_write      = ctrl.id_write;
    assign ctl.ifid_flush    = ctrl.ifid_flush;
    assign ctl.ctrl_flush    = ctrl.ctrl_flush;
    assign ctl.exmem_write   = ctrl.exmem_write;
    assign ctl.stall_timeout = timeout_q;
    assign ctl.pipe_state    = state_q;

`ifdef PERF_CNT_EN
    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_cnt_w;
    logic [CNT_W-1:0] flush_cnt_w;

    assign stall_inc = ctrl.ctrl_flush && ((state_q == ST_RUN) || (state_q == ST_STALL));
    assign flush_inc = ctrl.ifid_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_inc),
        .count_o (stall_cnt_w)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flush_inc),
        .count_o (flush_cnt_w)
    );

    assign ctl.stall_cnt = stall_cnt_w;
    assign ctl.flush_cnt = flush_cnt_w;
`else
    assign ctl.stall_cnt = {CNT_W{1'b0}};
    assign ctl.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: vector table plus multi-cycle corner sequences.
module tb_pipeline_stall_controller;

    localparam int unsigned BR_PENALTY = 2;
    localparam int unsigned MAX_STALL  = 3;
    localparam int unsigned CNT_W      = 3;

    // Enable bundle order: {PCwrite, Id_write, ifid_flush, ctrl_flush, exmem_write}
    localparam logic [4:0] O_N = 5'b11001;
    localparam logic [4:0] O_S = 5'b00011;
    localparam logic [4:0] O_B = 5'b11111;
    localparam logic [4:0] O_F = 5'b00000;

    typedef struct {
        logic       rst;
        logic       hdu;
        logic       br;
        logic       mem;
        logic       halt;
        logic [4:0] eo;
        logic [2:0] es;
        logic       et;
        bit         chk;
    } vec_t;

    typedef struct {
        bit               chk;
        logic [4:0]       eo;
        logic [2:0]       es;
        logic             et;
        logic [CNT_W-1:0] ecs;
        logic [CNT_W-1:0] ecf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_controller #(
        .BR_PENALTY (BR_PENALTY),
        .MAX_STALL  (MAX_STALL),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    always #5 clk = ~clk;

    exp_t             sb[$];
    exp_t             ce;
    int unsigned      n_chk  = 0;
    int unsigned      n_fail = 0;
    int unsigned      n_row  = 0;
    logic [CNT_W-1:0] m_scnt = '0;
    logic [CNT_W-1:0] m_fcnt = '0;

    function automatic vec_t mk(input logic r, input logic h, input logic b, input logic m,
                                input logic hl, input logic [4:0] eo, input logic [2:0] es,
                                input logic et, input bit chk);
        vec_t v;
        v.rst = r; v.hdu = h; v.br = b; v.mem = m; v.halt = hl;
        v.eo = eo; v.es = es; v.et = et; v.chk = chk;
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    task automatic step(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = v.rst;
        bus.hdu_stall = v.hdu;
        bus.br_taken  = v.br;
        bus.mem_busy  = v.mem;
        bus.halt      = v.halt;
        e.chk = v.chk;
        e.eo  = v.eo;
        e.es  = v.es;
        e.et  = v.et;
`ifdef PERF_CNT_EN
        e.ecs = m_scnt;
        e.ecf = m_fcnt;
`else
        e.ecs = '0;
        e.ecf = '0;
`endif
        sb.push_back(e);
        if (v.rst) begin
            m_scnt = '0;
            m_fcnt = '0;
        end else begin
            if (v.eo[1] && ((v.es == 3'd0) || (v.es == 3'd1))) m_scnt = sat_inc(m_scnt);
            if (v.eo[2]) m_fcnt = sat_inc(m_fcnt);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h, expected %0h", name, n_row, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            ce = sb.pop_front();
            if (ce.chk) begin
                check("enables", 32'({bus.PCwrite, bus.Id_write, bus.ifid_flush,
                                      bus.ctrl_flush, bus.exmem_write}), 32'(ce.eo));
                check("pipe_state", 32'(bus.pipe_state), 32'(ce.es));
                check("stall_timeout", 32'(bus.stall_timeout), 32'(ce.et));
                check("stall_cnt", 32'(bus.stall_cnt), 32'(ce.ecs));
                check("flush_cnt", 32'(bus.flush_cnt), 32'(ce.ecf));
            end
            n_row++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        rst           = 1'b1;
        bus.hdu_stall = 1'b0;
        bus.br_taken  = 1'b0;
        bus.mem_busy  = 1'b0;
        bus.halt      = 1'b0;

        // reset state, single load-use stall
        tbl.push_back(mk(1, 0, 0, 0, 0, O_N, 3'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_N, 3'd0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, O_S, 3'd0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_N, 3'd1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_N, 3'd0, 0, 1));
        // taken branch, penalty 2
        tbl.push_back(mk(0, 0, 1, 0, 0, O_B, 3'd0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_B, 3'd2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_B, 3'd2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_N, 3'd0, 0, 1));
        // branch and stall together: branch wins
        tbl.push_back(mk(0, 1, 1, 0, 0, O_B, 3'd0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, O_B, 3'd2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_B, 3'd2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_N, 3'd0, 0, 1));
        // third branch drives the 3-bit flush counter into saturation
        tbl.push_back(mk(0, 0, 1, 0, 0, O_B, 3'd0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_B, 3'd2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_B, 3'd2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_N, 3'd0, 0, 1));
        // mem_busy beats br_taken; freeze then resume RUN
        tbl.push_back(mk(0, 0, 1, 1, 0, O_F, 3'd0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, O_F, 3'd3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_N, 3'd3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_N, 3'd0, 0, 1));
        // halt beats everything; HALTED left only by rst
        tbl.push_back(mk(0, 0, 1, 1, 1, O_F, 3'd0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, O_F, 3'd4, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, O_F, 3'd4, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, O_F, 3'd4, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, O_N, 3'd0, 0, 1));

        foreach (tbl[i]) step(tbl[i]);

        // stall held 5 cycles: 3 stall cycles, forced release, sticky timeout, rst clears it
        step(mk(0, 1, 0, 0, 0, O_S, 3'd0, 0, 1));
        step(mk(0, 1, 0, 0, 0, O_S, 3'd1, 0, 1));
        step(mk(0, 1, 0, 0, 0, O_S, 3'd1, 0, 1));
        step(mk(0, 1, 0, 0, 0, O_N, 3'd1, 0, 1));
        step(mk(0, 1, 0, 0, 0, O_S, 3'd0, 1, 1));
        step(mk(0, 0, 0, 0, 0, O_N, 3'd1, 1, 1));
        step(mk(0, 0, 0, 0, 0, O_N, 3'd0, 1, 1));
        step(mk(1, 0, 0, 0, 0, O_N, 3'd0, 1, 1));
        step(mk(0, 0, 0, 0, 0, O_N, 3'd0, 0, 1));

        // mem_busy for 4 cycles in the middle of a flush
        step(mk(0, 0, 1, 0, 0, O_B, 3'd0, 0, 1));
        step(mk(0, 0, 0, 1, 0, O_F, 3'd2, 0, 1));
        step(mk(0, 0, 0, 1, 0, O_F, 3'd3, 0, 1));
        step(mk(0, 0, 0, 1, 0, O_F, 3'd3, 0, 1));
        step(mk(0, 0, 0, 1, 0, O_F, 3'd3, 0, 1));
        step(mk(0, 0, 0, 0, 0, O_B, 3'd3, 0, 1));
        step(mk(0, 0, 0, 0, 0, O_B, 3'd2, 0, 1));
        step(mk(0, 0, 0, 0, 0, O_N, 3'd0, 0, 1));

        // mem_busy in the middle of a stall: stall count held, timeout after resume
        step(mk(0, 1, 0, 0, 0, O_S, 3'd0, 0, 1));
        step(mk(0, 1, 0, 1, 0, O_F, 3'd1, 0, 1));
        step(mk(0, 1, 0, 1, 0, O_F, 3'd3, 0, 1));
        step(mk(0, 1, 0, 0, 0, O_S, 3'd3, 0, 1));
        step(mk(0, 1, 0, 0, 0, O_S, 3'd1, 0, 1));
        step(mk(0, 1, 0, 0, 0, O_N, 3'd1, 0, 1));
        step(mk(0, 0, 0, 0, 0, O_N, 3'd0, 1, 1));

        // rst pulsed mid-stall
        step(mk(0, 1, 0, 0, 0, O_S, 3'd0, 1, 1));
        step(mk(0, 1, 0, 0, 0, O_S, 3'd1, 1, 1));
        step(mk(1, 1, 0, 0, 0, O_S, 3'd1, 1, 1));
        step(mk(0, 0, 0, 0, 0, O_N, 3'd0, 0, 1));

        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.hdu_stall = 1'b0;
        bus.br_taken  = 1'b0;
        bus.mem_busy  = 1'b0;
        bus.halt      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
